// File: rtl/mul_share_pkg.sv
// Shared types and constants for the shared-multiplier arbiter.
package mul_share_pkg;

  localparam int OP_W      = 32;
  localparam int RES_W     = 64;
  // Largest requester count the tag type is sized for; the arbiter default.
  localparam int N_REQ_MAX = 4;
  localparam int TAG_W     = (N_REQ_MAX > 1) ? $clog2(N_REQ_MAX) : 1;

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    tag_t                    tag;
    logic signed [RES_W-1:0] result;
  } rsp_entry_t;

  // Requester index reached by stepping 'off' places past 'base', with wrap.
  function automatic tag_t wrap_idx(input int base, input int off, input int n);
    return tag_t'((base + off) % n);
  endfunction

endpackage

// File: rtl/mul_share_rsp_fifo.sv
// Synchronous response FIFO of {tag, result} entries with occupancy flags.
module mul_share_rsp_fifo
  import mul_share_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  rsp_entry_t       push_data_i,
  input  logic             pop_i,
  output rsp_entry_t       head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  rsp_entry_t       mem_q [DEPTH];
  rsp_entry_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign head_o     = mem_q[rd_ptr_q];
  // A push into a full FIFO is only lost when no pop frees the head slot.
  assign overflow_o = push_i && full_o && !pop_i;

  // Next-state for storage, pointers (wrapping at DEPTH) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_push  = push_i && (!full_o || pop_i);
    do_pop   = pop_i && !empty_o;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers; reset empties the FIFO and clears storage.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable signed multiplier
// between N_REQ requesters, with credit-protected in-order result return.
//
// Handshakes: a transfer happens on a clock edge where valid and ready are
// both high. req_ready_o is combinational from req_valid_i, so a requester
// raises valid without waiting for ready and keeps a/b stable until ready.
// rsp_valid_o is raised for the owner of the FIFO head; the owner pops it
// with rsp_ready_i on any edge where rsp_valid_o is high.
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter int N_REQ     = N_REQ_MAX,
  parameter int LATENCY   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_REQ-1:0]            req_valid_i,
  output logic [N_REQ-1:0]            req_ready_o,
  input  logic [N_REQ-1:0][OP_W-1:0]  req_a_i,
  input  logic [N_REQ-1:0][OP_W-1:0]  req_b_i,
  output logic [N_REQ-1:0]            rsp_valid_o,
  input  logic [N_REQ-1:0]            rsp_ready_i,
  output logic [RES_W-1:0]            rsp_result_o,
  output logic                        mul_valid_o,
  output logic [OP_W-1:0]             mul_a_o,
  output logic [OP_W-1:0]             mul_b_o,
  input  logic                        mul_valid_i,
  input  logic [RES_W-1:0]            mul_result_i,
  output logic                        err_o
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);

  // Issue register and arbiter state.
  logic              rdy_en_q;
  tag_t              ptr_q, ptr_d;
  logic              iss_valid_q, iss_valid_d;
  tag_t              iss_tag_q, iss_tag_d;
  logic [OP_W-1:0]   mul_a_q, mul_a_d;
  logic [OP_W-1:0]   mul_b_q, mul_b_d;
  logic              err_q, err_d;
  logic [RES_W-1:0]  rsp_last_q, rsp_last_d;

  // Arbitration and credit.
  logic              gnt_found;
  tag_t              gnt_idx;
  logic              issue_ok;
  logic              hs;
  int                used;

  // Tag pipe outputs, aligned with mul_valid_i.
  logic              exp_valid;
  tag_t              exp_tag;
  logic [7:0]        pipe_cnt;

  // Response FIFO.
  rsp_entry_t        push_entry;
  rsp_entry_t        fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, fifo_overflow;
  logic              fifo_pop;

  // Scan for the first valid requester after the last winner.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!gnt_found && req_valid_i[wrap_idx(int'(ptr_q), k, N_REQ)]) begin
        gnt_found = 1'b1;
        gnt_idx   = wrap_idx(int'(ptr_q), k, N_REQ);
      end
    end
  end

  // Credits count every result that still needs a FIFO slot; a same-cycle
  // pop is not seen until the count register updates. rdy_en_q keeps ready
  // low while in reset and for the first edge after it.
  always_comb begin
    used     = int'(fifo_count) + (iss_valid_q ? 1 : 0) + int'(pipe_cnt);
    issue_ok = rdy_en_q && !fifo_full && (used < RSP_DEPTH);
    hs       = issue_ok && gnt_found;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready_o[i] = hs && (gnt_idx == tag_t'(i));
    end
  end

  // Next issue register contents; operands hold their value when idle.
  always_comb begin
    ptr_d       = ptr_q;
    iss_valid_d = hs;
    iss_tag_d   = iss_tag_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    if (hs) begin
      ptr_d     = gnt_idx;
      iss_tag_d = gnt_idx;
      mul_a_d   = req_a_i[gnt_idx];
      mul_b_d   = req_b_i[gnt_idx];
    end
  end

  assign mul_valid_o = iss_valid_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;

  if (LATENCY > 0) begin : g_pipe
    logic [LATENCY-1:0] pv_q, pv_d;
    tag_t               pt_q [LATENCY];
    tag_t               pt_d [LATENCY];

    // Shift {valid, tag} one stage per cycle behind the issue register.
    always_comb begin
      pv_d[0] = iss_valid_q;
      pt_d[0] = iss_tag_q;
      for (int i = 1; i < LATENCY; i++) begin
        pv_d[i] = pv_q[i-1];
        pt_d[i] = pt_q[i-1];
      end
    end

    // Tag pipe registers, cleared on reset alongside the multiplier.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        pv_q <= '0;
        for (int i = 0; i < LATENCY; i++) pt_q[i] <= '0;
      end else begin
        pv_q <= pv_d;
        pt_q <= pt_d;
      end
    end

    // Number of valid stages still waiting for their multiplier result.
    always_comb begin
      pipe_cnt = '0;
      for (int i = 0; i < LATENCY; i++) pipe_cnt = pipe_cnt + {7'd0, pv_q[i]};
    end

    assign exp_valid = pv_q[LATENCY-1];
    assign exp_tag   = pt_q[LATENCY-1];
  end else begin : g_nopipe
    assign pipe_cnt  = '0;
    assign exp_valid = iss_valid_q;
    assign exp_tag   = iss_tag_q;
  end

  // Results are pushed whenever the multiplier reports one, even if unexpected.
  always_comb begin
    push_entry        = '0;
    push_entry.tag    = exp_tag;
    push_entry.result = mul_result_i;
  end

  mul_share_rsp_fifo #(
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (mul_valid_i),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .overflow_o  (fifo_overflow)
  );

  // Present the head to its owner only; the result bus holds when empty.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      rsp_valid_o[i] = !fifo_empty && (fifo_head.tag == tag_t'(i));
    end
    fifo_pop     = !fifo_empty && rsp_ready_i[fifo_head.tag];
    rsp_result_o = fifo_empty ? rsp_last_q : fifo_head.result;
    rsp_last_d   = rsp_result_o;
  end

  // Sticky error on a valid mismatch against the tag pipe or a lost push.
  always_comb begin
    err_d = err_q || (mul_valid_i != exp_valid) || fifo_overflow;
  end

  assign err_o = err_q;

  // Arbiter, issue and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdy_en_q    <= 1'b0;
      ptr_q       <= tag_t'(N_REQ - 1);
      iss_valid_q <= 1'b0;
      iss_tag_q   <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      err_q       <= 1'b0;
      rsp_last_q  <= '0;
    end else begin
      rdy_en_q    <= 1'b1;
      ptr_q       <= ptr_d;
      iss_valid_q <= iss_valid_d;
      iss_tag_q   <= iss_tag_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      err_q       <= err_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter with a one-cycle signed multiplier model.
module tb_mul_share_arbiter;

  localparam int N_REQ     = 4;
  localparam int LATENCY   = 1;
  localparam int RSP_DEPTH = 4;
  localparam int EW        = 66;

  logic                    clk_i = 1'b0;
  logic                    rst_ni = 1'b0;
  logic [N_REQ-1:0]        req_valid_i = '0;
  logic [N_REQ-1:0]        req_ready_o;
  logic [N_REQ-1:0][31:0]  req_a_i = '0;
  logic [N_REQ-1:0][31:0]  req_b_i = '0;
  logic [N_REQ-1:0]        rsp_valid_o;
  logic [N_REQ-1:0]        rsp_ready_i = '0;
  logic [63:0]             rsp_result_o;
  logic                    mul_valid_o;
  logic [31:0]             mul_a_o, mul_b_o;
  logic                    mul_valid_i;
  logic [63:0]             mul_result_i;
  logic                    err_o;

  logic                    inject = 1'b0;
  logic                    mv_q;
  logic signed [63:0]      mr_q;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state, owned by the monitor.
  logic [EW-1:0] exp_q[$];
  int            hs_cnt = 0;
  int            pop_cnt = 0;
  int            last_g = N_REQ - 1;

  mul_share_arbiter #(
    .N_REQ(N_REQ), .LATENCY(LATENCY), .RSP_DEPTH(RSP_DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_result_o(rsp_result_o),
    .mul_valid_o(mul_valid_o), .mul_a_o(mul_a_o), .mul_b_o(mul_b_o),
    .mul_valid_i(mul_valid_i), .mul_result_i(mul_result_i),
    .err_o(err_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // One-cycle signed multiplier sharing the reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mv_q <= 1'b0;
      mr_q <= '0;
    end else begin
      mv_q <= mul_valid_o;
      mr_q <= $signed(mul_a_o) * $signed(mul_b_o);
    end
  end
  assign mul_valid_i  = mv_q | inject;
  assign mul_result_i = mr_q;

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    return sa * sb;
  endfunction

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'h8000_0000;
      1: return 32'h7fff_ffff;
      2: return 32'hffff_ffff;
      3: return 32'd0;
      default: return $urandom();
    endcase
  endfunction

  task automatic check(input string nm, input logic [71:0] act, input logic [71:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor / scoreboard: samples mid-cycle, ahead of the next active edge.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        exp_q.delete();
        hs_cnt  = 0;
        pop_cnt = 0;
        last_g  = N_REQ - 1;
      end else begin
        if (chk_en) begin
          logic [N_REQ-1:0] exp_rdy;
          int g;
          g = -1;
          for (int k = 1; k <= N_REQ; k++) begin
            if (g < 0 && req_valid_i[(last_g + k) % N_REQ]) g = (last_g + k) % N_REQ;
          end
          exp_rdy = '0;
          if (g >= 0 && (hs_cnt - pop_cnt) < RSP_DEPTH) exp_rdy[g] = 1'b1;
          check("ready", 72'(req_ready_o), 72'(exp_rdy));
          check("err_quiet", 72'(err_o), 72'(0));
        end
        for (int i = 0; i < N_REQ; i++) begin
          if (req_valid_i[i] && req_ready_o[i]) begin
            exp_q.push_back({2'(i), ref_mul(req_a_i[i], req_b_i[i])});
            last_g = i;
            hs_cnt++;
          end
        end
        if (chk_en && rsp_valid_o != '0) begin
          int t;
          t = 0;
          for (int i = N_REQ - 1; i >= 0; i--) if (rsp_valid_o[i]) t = i;
          check("rsp_onehot", 72'($onehot(rsp_valid_o)), 72'(1));
          if (exp_q.size() == 0) begin
            check("rsp_unexpected", 72'(rsp_valid_o), 72'(0));
          end else begin
            check("rsp", 72'({2'(t), rsp_result_o}), 72'(exp_q[0]));
            if (rsp_ready_i[t]) begin
              void'(exp_q.pop_front());
              pop_cnt++;
            end
          end
        end
      end
    end
  end

  task automatic do_reset();
    req_valid_i = '0;
    rsp_ready_i = '0;
    inject      = 1'b0;
    rst_ni      = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic drain();
    int n;
    req_valid_i = '0;
    rsp_ready_i = '1;
    n = 0;
    while ((exp_q.size() != 0 || rsp_valid_o != '0) && n < 100) begin
      @(negedge clk_i);
      n++;
    end
    check("drain", 72'(exp_q.size()), 72'(0));
    @(posedge clk_i); #1;
  endtask

  // Single request with latency, value and pulse-width checks.
  task automatic one_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_r, input string nm);
    int n;
    bit got;
    req_valid_i      = '0;
    rsp_ready_i      = '1;
    req_valid_i[idx] = 1'b1;
    req_a_i[idx]     = a;
    req_b_i[idx]     = b;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk_i);
      got = req_ready_o[idx];
      n++;
    end
    check({nm, "_hs"}, 72'(got), 72'(1));
    @(posedge clk_i); #1;
    req_valid_i[idx] = 1'b0;
    got = 1'b0;
    n = 0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk_i);
      if (rsp_valid_o[idx]) begin
        got = 1'b1;
        n = c;
      end
    end
    check({nm, "_lat"}, 72'(n), 72'(LATENCY + 2));
    check({nm, "_val"}, 72'(rsp_result_o), 72'(exp_r));
    @(negedge clk_i);
    check({nm, "_pulse"}, 72'(rsp_valid_o), 72'(0));
    @(posedge clk_i); #1;
  endtask

  // Driver and directed sequences.
  initial begin
    logic [N_REQ-1:0] hs;
    int n;

    #1;
    check("rst_ready", 72'(req_ready_o), 72'(0));
    check("rst_rsp_valid", 72'(rsp_valid_o), 72'(0));
    check("rst_mul_valid", 72'(mul_valid_o), 72'(0));
    check("rst_ops", 72'({mul_a_o, mul_b_o}), 72'(0));
    check("rst_result", 72'(rsp_result_o), 72'(0));
    check("rst_err", 72'(err_o), 72'(0));
    do_reset();
    chk_en = 1'b1;

    one_req(0, 32'd3, -32'sd4, 64'hffff_ffff_ffff_fff4, "single");
    one_req(2, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "ext_min_min");
    one_req(3, 32'h7fff_ffff, 32'h7fff_ffff, 64'h3fff_ffff_0000_0001, "ext_max_max");
    one_req(1, 32'h8000_0000, 32'hffff_ffff, 64'h0000_0000_8000_0000, "ext_min_neg1");

    // All four requesters continuously valid: strict 0,1,2,3 rotation.
    chk_en = 1'b0;
    do_reset();
    chk_en = 1'b1;
    rsp_ready_i = '1;
    for (int i = 0; i < N_REQ; i++) begin
      req_a_i[i] = rand_op();
      req_b_i[i] = rand_op();
    end
    req_valid_i = '1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      check("rr_grant", 72'(req_ready_o), 72'(1 << (k % N_REQ)));
      hs = req_valid_i & req_ready_o;
      @(posedge clk_i); #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (hs[i]) begin
          req_a_i[i] = rand_op();
          req_b_i[i] = rand_op();
        end
      end
    end
    drain();

    // Backpressure: four credits then stall, resume once drained.
    rsp_ready_i    = '0;
    req_valid_i[1] = 1'b1;
    req_a_i[1]     = rand_op();
    req_b_i[1]     = rand_op();
    n = 0;
    repeat (12) begin
      @(negedge clk_i);
      hs = req_valid_i & req_ready_o;
      if (hs[1]) n++;
      @(posedge clk_i); #1;
      if (hs[1]) begin
        req_a_i[1] = rand_op();
        req_b_i[1] = rand_op();
      end
    end
    check("bp_credits", 72'(n), 72'(RSP_DEPTH));
    check("bp_err", 72'(err_o), 72'(0));
    rsp_ready_i[1] = 1'b1;
    n = 0;
    repeat (12) begin
      @(negedge clk_i);
      hs = req_valid_i & req_ready_o;
      if (hs[1]) n++;
      @(posedge clk_i); #1;
      if (hs[1]) begin
        req_a_i[1] = rand_op();
        req_b_i[1] = rand_op();
      end
    end
    check("bp_resume", 72'(n >= 8), 72'(1));
    drain();

    // Randomized traffic with random response backpressure.
    for (int c = 0; c < 600; c++) begin
      @(negedge clk_i);
      hs = req_valid_i & req_ready_o;
      @(posedge clk_i); #1;
      for (int i = 0; i < N_REQ; i++) begin
        if (!req_valid_i[i] || hs[i]) begin
          req_valid_i[i] = ($urandom_range(0, 9) < 6);
          req_a_i[i]     = rand_op();
          req_b_i[i]     = rand_op();
        end
        rsp_ready_i[i] = ($urandom_range(0, 3) != 0);
      end
    end
    drain();

    // Spurious multiplier valid with nothing in flight.
    chk_en      = 1'b0;
    rsp_ready_i = '0;
    @(negedge clk_i);
    check("err_before", 72'(err_o), 72'(0));
    @(posedge clk_i); #1 inject = 1'b1;
    @(posedge clk_i); #1 inject = 1'b0;
    @(negedge clk_i);
    check("err_set", 72'(err_o), 72'(1));
    repeat (5) @(posedge clk_i);
    @(negedge clk_i);
    check("err_sticky", 72'(err_o), 72'(1));
    do_reset();
    check("err_cleared", 72'(err_o), 72'(0));

    // Reset with three results buffered.
    chk_en         = 1'b1;
    rsp_ready_i    = '0;
    req_valid_i[0] = 1'b1;
    req_a_i[0]     = rand_op();
    req_b_i[0]     = rand_op();
    n = 0;
    while (n < 3) begin
      @(negedge clk_i);
      hs = req_valid_i & req_ready_o;
      if (hs[0]) n++;
      @(posedge clk_i); #1;
      if (hs[0]) begin
        req_a_i[0] = rand_op();
        req_b_i[0] = rand_op();
      end
      if (n == 3) req_valid_i[0] = 1'b0;
    end
    repeat (4) @(posedge clk_i);
    #3;
    chk_en      = 1'b0;
    req_valid_i = '1;
    rst_ni      = 1'b0;
    #1;
    check("mid_rst_ready", 72'(req_ready_o), 72'(0));
    check("mid_rst_rsp_valid", 72'(rsp_valid_o), 72'(0));
    check("mid_rst_mul", 72'({mul_valid_o, mul_a_o, mul_b_o}), 72'(0));
    check("mid_rst_result", 72'(rsp_result_o), 72'(0));
    do_reset();
    chk_en      = 1'b1;
    rsp_ready_i = '1;
    repeat (3) begin
      @(negedge clk_i);
      check("post_rst_no_stale", 72'(rsp_valid_o), 72'(0));
    end
    @(posedge clk_i); #1 req_valid_i = '1;
    @(negedge clk_i);
    check("post_rst_grant", 72'(req_ready_o), 72'(4'b0001));
    @(posedge clk_i); #1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
